// File: rtl/tlb_assoc_param.sv
// Fully-associative ASID-tagged TLB with tree-PLRU replacement, selective flush and
// a single outstanding page-table walk that is discarded if a flush races it.
module tlb_assoc_param #(
    parameter int ENTRIES = 8,
    parameter int VPN_W   = 27,
    parameter int PPN_W   = 20,
    parameter int ASID_W  = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [VPN_W-1:0]  req_vpn,
    input  logic              req_store,
    input  logic              req_fetch,
    input  logic              vm_enabled,
    input  logic [ASID_W-1:0] cur_asid,
    input  logic              priv_s,
    input  logic              status_pum,
    input  logic              status_mxr,
    output logic              resp_miss,
    output logic [PPN_W-1:0]  resp_ppn,
    output logic              resp_xcpt_ld,
    output logic              resp_xcpt_st,
    output logic              resp_xcpt_if,
    output logic              ptw_req_valid,
    input  logic              ptw_req_ready,
    output logic [VPN_W-1:0]  ptw_req_vpn,
    input  logic              ptw_resp_valid,
    input  logic [PPN_W-1:0]  ptw_resp_ppn,
    input  logic [5:0]        ptw_resp_perm,
    input  logic              flush_valid,
    input  logic              flush_asid_en,
    input  logic              flush_vpn_en,
    input  logic [ASID_W-1:0] flush_asid,
    input  logic [VPN_W-1:0]  flush_vpn,
    output logic [1:0]        o_dbg_state
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        S_READY    = 2'd0,
        S_REQUEST  = 2'd1,
        S_WAIT     = 2'd2,
        S_WAIT_INV = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [ENTRIES-1:0]  r_valid;
    logic [VPN_W-1:0]    r_tag_vpn  [ENTRIES];
    logic [ASID_W-1:0]   r_tag_asid [ENTRIES];
    logic [PPN_W-1:0]    r_ppn      [ENTRIES];
    logic [5:0]          r_perm     [ENTRIES];   // {g,d,u,x,w,r}
    logic [ENTRIES-1:0]  r_plru, w_plru_next;    // heap-ordered nodes 1..ENTRIES-1, bit 0 unused
    logic [VPN_W-1:0]    r_cap_vpn;
    logic [ASID_W-1:0]   r_cap_asid;
    logic [IDX_W-1:0]    r_victim;
    logic                r_victim_flushed;

    logic [ENTRIES-1:0]  w_hit, w_clear, w_refill_onehot;
    logic [IDX_W-1:0]    w_hit_idx, w_first_inv, w_plru_victim, w_touch_idx, w_refill_idx;
    logic                w_hit_any, w_any_inv, w_capture, w_refill, w_touch;
    logic [5:0]          w_perm;
    logic                w_priv_bad;

    always_comb begin
        w_hit       = '0;
        w_clear     = '0;
        w_hit_idx   = '0;
        w_first_inv = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_hit[i] = r_valid[i] && (r_tag_vpn[i] == req_vpn) &&
                       (r_perm[i][5] || (r_tag_asid[i] == cur_asid));
            w_clear[i] = flush_valid &&
                         (!flush_asid_en || ((r_tag_asid[i] == flush_asid) && !r_perm[i][5])) &&
                         (!flush_vpn_en || (r_tag_vpn[i] == flush_vpn));
            if (w_hit[i]) w_hit_idx = IDX_W'(i);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_first_inv = IDX_W'(i);
        end
    end

    assign w_hit_any  = |w_hit;
    assign w_any_inv  = ~&r_valid;
    assign w_perm     = r_perm[w_hit_idx];
    assign w_priv_bad = (w_perm[3] & priv_s & (status_pum | req_fetch)) | (~w_perm[3] & ~priv_s);

    always_comb begin
        resp_miss    = 1'b0;
        resp_ppn     = '0;
        resp_xcpt_ld = 1'b0;
        resp_xcpt_st = 1'b0;
        resp_xcpt_if = 1'b0;
        if (!vm_enabled) begin
            resp_ppn = PPN_W'(req_vpn);
        end else begin
            resp_miss = req_valid & ~w_hit_any;
            if (w_hit_any) begin
                resp_ppn     = r_ppn[w_hit_idx];
                resp_xcpt_ld = ~req_store & ~req_fetch &
                               (w_priv_bad | ~(w_perm[0] | (w_perm[2] & status_mxr)));
                resp_xcpt_st = req_store & (w_priv_bad | ~w_perm[1] | ~w_perm[4]);
                resp_xcpt_if = req_fetch & (w_priv_bad | ~w_perm[2]);
            end
        end
    end

    // Handshake: a lookup is accepted when req_valid & req_ready; a walk is handed
    // off when ptw_req_valid & ptw_req_ready; ptw_resp_valid is a one-cycle pulse.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_refill     = 1'b0;
        case (r_state)
            S_READY: begin
                if (req_valid && vm_enabled && !w_hit_any && !flush_valid) begin
                    w_state_next = S_REQUEST;
                    w_capture    = 1'b1;
                end
            end
            S_REQUEST: begin
                if (ptw_req_ready) w_state_next = flush_valid ? S_WAIT_INV : S_WAIT;
                else if (flush_valid) w_state_next = S_READY;
            end
            S_WAIT: begin
                if (flush_valid) begin
                    w_state_next = ptw_resp_valid ? S_READY : S_WAIT_INV;
                end else if (ptw_resp_valid) begin
                    w_state_next = S_READY;
                    w_refill     = 1'b1;
                end
            end
            S_WAIT_INV: begin
                if (ptw_resp_valid) w_state_next = S_READY;
            end
            default: w_state_next = S_READY;
        endcase
    end

    always_comb begin
        logic [IDX_W-1:0] w_vnode;
        w_plru_victim = '0;
        w_vnode       = IDX_W'(1);
        for (int l = 0; l < IDX_W; l++) begin
            w_plru_victim[IDX_W-1-l] = r_plru[w_vnode];
            w_vnode = (w_vnode << 1) | IDX_W'(r_plru[w_vnode]);
        end
    end

    // Each node on the touched path is pointed away from the touched leaf.
    assign w_touch      = w_refill | (req_valid & req_ready & vm_enabled & w_hit_any);
    assign w_refill_idx = r_victim_flushed ? w_first_inv : r_victim;
    assign w_touch_idx  = w_refill ? w_refill_idx : w_hit_idx;

    always_comb begin
        logic [IDX_W-1:0] w_tnode;
        w_plru_next = r_plru;
        w_tnode     = IDX_W'(1);
        if (w_touch) begin
            for (int l = 0; l < IDX_W; l++) begin
                w_plru_next[w_tnode] = ~w_touch_idx[IDX_W-1-l];
                w_tnode = (w_tnode << 1) | IDX_W'(w_touch_idx[IDX_W-1-l]);
            end
        end
    end

    assign w_refill_onehot = w_refill ? (ENTRIES'(1) << w_refill_idx) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_READY;
            r_valid          <= '0;
            r_plru           <= '0;
            r_victim_flushed <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= (r_valid & ~w_clear) | w_refill_onehot;
            if (w_touch) r_plru <= w_plru_next;
            if (w_capture) r_victim_flushed <= 1'b0;
            else if (r_state != S_READY && w_clear[r_victim]) r_victim_flushed <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_cap_vpn  <= req_vpn;
            r_cap_asid <= cur_asid;
            r_victim   <= w_any_inv ? w_first_inv : w_plru_victim;
        end
        if (w_refill) begin
            r_tag_vpn[w_refill_idx]  <= r_cap_vpn;
            r_tag_asid[w_refill_idx] <= r_cap_asid;
            r_ppn[w_refill_idx]      <= ptw_resp_ppn;
            r_perm[w_refill_idx]     <= ptw_resp_perm;
        end
    end

    assign req_ready     = (r_state == S_READY);
    assign ptw_req_valid = (r_state == S_REQUEST);
    assign ptw_req_vpn   = r_cap_vpn;
    assign o_dbg_state   = r_state;
endmodule
